ahb_slave_interface: RTL

- AHB-Lite slave front end of the AHB2APB bridge. Responds to transfers issued by `ahb_master_interface`.
- Qualifies and captures each address phase, decodes it to one of three peripheral selects, and presents a held request to the downstream APB controller.
- Stretches the AHB data phase with `hr_readyout` until the controller signals completion.
- Generates the two-cycle AHB ERROR response for out-of-range transfers.

---
 rtl/ahb_slave_interface.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_interface.sv
// ----------------------------------------------------------------------------
// ahb_slave_interface
//
// AHB-Lite slave front end of the AHB2APB bridge. Qualifies each address
// phase, decodes it to one of three peripheral slots and holds a request for
// the downstream APB controller until that controller reports completion.
// The AHB data phase is stretched through hr_readyout meanwhile. Reads take
// one extra cycle so that the registered hrdata is valid when HREADY rises.
// Out-of-range transfers get the two-cycle ERROR response.
//
// Ports:
//   hclk, hresetn        clock, asynchronous active-low reset
//   haddr, htrans,
//   hwrite, hready_in    AHB address-phase inputs
//   hwdata               AHB write data (data phase)
//   xfer_done, rd_data   completion strobe and read data from the controller
//   hr_readyout, hresp,
//   hrdata               AHB slave response
//   req_valid, req_addr,
//   req_write, req_wdata,
//   tempselx             request to the APB controller, one-hot slot select
// ----------------------------------------------------------------------------
module ahb_slave_interface #(
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter logic [31:0] ADDR_LIMIT = 32'h8C00_0000,
   parameter int unsigned SLOT_SHIFT = 26
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic        hready_in,
   input  logic [31:0] hwdata,
   input  logic        xfer_done,
   input  logic [31:0] rd_data,
   output logic        hr_readyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic        req_valid,
   output logic [31:0] req_addr,
   output logic        req_write,
   output logic [31:0] req_wdata,
   output logic [2:0]  tempselx
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ_OUT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t      state_q,     state_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] req_addr_q,  req_addr_d;
   logic        req_write_q, req_write_d;
   logic [2:0]  tempselx_q,  tempselx_d;
   logic [31:0] hrdata_q,    hrdata_d;

   logic        act;
   logic        in_range;
   logic        good;
   logic        bad;
   logic        sample;
   logic [31:0] offset;
   logic [31:0] slot;
   logic [2:0]  sel_onehot;

   // Only NONSEQ/SEQ with HREADY high form an address phase.
   assign act      = hready_in && ((htrans == 2'b10) || (htrans == 2'b11));
   assign in_range = (haddr >= ADDR_BASE) && (haddr < ADDR_LIMIT);
   assign good     = act && in_range;
   assign bad      = act && !in_range;

   assign offset = haddr - ADDR_BASE;
   assign slot   = offset >> SLOT_SHIFT;

   always_comb begin
      sel_onehot = 3'b000;
      case (slot)
         32'd0:   sel_onehot = 3'b001;
         32'd1:   sel_onehot = 3'b010;
         32'd2:   sel_onehot = 3'b100;
         default: sel_onehot = 3'b000;
      endcase
   end

   // Next-state and request capture.
   always_comb begin
      state_d     = state_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_write_d = req_write_q;
      tempselx_d  = tempselx_q;
      hrdata_d    = hrdata_q;
      sample      = 1'b0;

      case (state_q)
         ST_IDLE, ST_ERR2, ST_READ_OUT: sample = 1'b1;
         ST_WAIT: begin
            if (xfer_done) begin
               if (req_write_q) begin
                  sample = 1'b1;
               end else begin
                  // Read: latch data now, present it next cycle with HREADY high.
                  hrdata_d    = rd_data;
                  req_valid_d = 1'b0;
                  state_d     = ST_READ_OUT;
               end
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase

      if (sample) begin
         if (good) begin
            state_d     = ST_WAIT;
            req_valid_d = 1'b1;
            req_addr_d  = haddr;
            req_write_d = hwrite;
            tempselx_d  = sel_onehot;
         end else if (bad) begin
            state_d     = ST_ERR1;
            req_valid_d = 1'b0;
            tempselx_d  = 3'b000;
         end else begin
            state_d     = ST_IDLE;
            req_valid_d = 1'b0;
            tempselx_d  = 3'b000;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q     <= ST_IDLE;
         req_valid_q <= 1'b0;
         req_addr_q  <= 32'h0;
         req_write_q <= 1'b0;
         tempselx_q  <= 3'b000;
         hrdata_q    <= 32'h0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_write_q <= req_write_d;
         tempselx_q  <= tempselx_d;
         hrdata_q    <= hrdata_d;
      end
   end

   // Response: a write completes in the xfer_done cycle, a read one cycle later.
   always_comb begin
      hr_readyout = 1'b1;
      hresp       = 1'b0;
      case (state_q)
         ST_WAIT: hr_readyout = xfer_done && req_write_q;
         ST_ERR1: begin
            hr_readyout = 1'b0;
            hresp       = 1'b1;
         end
         ST_ERR2: hresp = 1'b1;
         default: begin
            hr_readyout = 1'b1;
            hresp       = 1'b0;
         end
      endcase
   end

   assign req_valid = req_valid_q;
   assign req_addr  = req_addr_q;
   assign req_write = req_write_q;
   assign tempselx  = tempselx_q;
   assign hrdata    = hrdata_q;
   assign req_wdata = hwdata;

endmodule
